// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN parameter load path.
//   BYTE_W          : width of the parameter byte port and of the serializer registers
//   WEIGHT_BITS     : binary weights per neuron
//   BIAS_BITS       : bias field width per neuron
//   BITS_PER_NEURON : length of one neuron's segment of the parameter shift chain
//   loader_state_e  : loader FSM states
package bnn_pkg;

  localparam int BYTE_W          = 8;
  localparam int WEIGHT_BITS     = 8;
  localparam int BIAS_BITS       = 3;
  localparam int BITS_PER_NEURON = WEIGHT_BITS + BIAS_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/param_serializer.sv
// Byte-wide parallel-in/serial-out register feeding the chain head, plus a
// serial-in/parallel-out register collecting the bits leaving the chain tail.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : zero both registers (highest priority)
//   load_i      : load byte_i into the PISO
//   shift_i     : shift PISO left by one and shift ser_in_i into the SIPO LSB
//   byte_i      : parallel byte, MSB leaves first
//   ser_in_i    : bit arriving from the chain tail
//   ser_out_o   : current PISO MSB (next bit to send)
//   capture_o   : SIPO contents as they will be after this cycle's shift
module param_serializer
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              ser_in_i,
  output logic              ser_out_o,
  output logic [BYTE_W-1:0] capture_o
);

  logic [BYTE_W-1:0] piso_q, piso_d;
  logic [BYTE_W-1:0] sipo_q, sipo_d;

  always_comb begin
    piso_d = piso_q;
    sipo_d = sipo_q;
    if (clear_i) begin
      piso_d = '0;
      sipo_d = '0;
    end else begin
      if (load_i) begin
        piso_d = byte_i;
      end else if (shift_i) begin
        piso_d = {piso_q[BYTE_W-2:0], 1'b0};
      end
      if (shift_i) begin
        sipo_d = capture_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_q <= '0;
      sipo_q <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
    end
  end

  assign ser_out_o = piso_q[BYTE_W-1];
  // Lets the owner register a complete readback byte in the same cycle the
  // last bit of that byte is captured.
  assign capture_o = {sipo_q[BYTE_W-2:0], ser_in_i};

endmodule

// File: rtl/bnn_param_loader.sv
// Serial parameter loader for the BNN neuron chain. Accepts bytes over a
// valid/ready port, shifts them MSB-first into the chain (one bit per setup
// cycle) until NEURONS*11 bits have been sent, and returns the bits pushed
// out of the chain tail as readback bytes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a load (only honoured when idle)
//   in_data/in_valid    : parameter byte stream; in_ready accepts a byte
//   setup, param_in     : chain shift enable and serial data to chain head
//   param_out           : serial data from chain tail
//   busy, done          : load in progress / one-cycle completion pulse
//   rb_data, rb_valid   : readback byte (first captured bit at MSB) and strobe
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int NEURONS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              setup,
  output logic              param_in,
  input  logic              param_out,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int TOTAL = NEURONS * BITS_PER_NEURON;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic              ser_clear, ser_load, ser_shift, ser_out;
  logic [BYTE_W-1:0] capture;

  param_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (ser_clear),
    .load_i    (ser_load),
    .shift_i   (ser_shift),
    .byte_i    (in_data),
    .ser_in_i  (param_out),
    .ser_out_o (ser_out),
    .capture_o (capture)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bcnt_d     = bcnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    ser_clear  = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT_BYTE;
          bit_cnt_d = '0;
          ser_clear = 1'b1;
        end
      end
      ST_WAIT_BYTE: begin
        // in_ready is high throughout this state, so in_valid alone is the handshake.
        if (in_valid) begin
          ser_load = 1'b1;
          bcnt_d   = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        bcnt_d    = bcnt_q + 3'd1;
        if (bit_cnt_q == LAST_BIT) begin
          // End of load wins over end of byte. A partial final byte holds
          // bcnt_q+1 captured bits in its low end; left-justify them.
          state_d    = ST_DONE;
          rb_valid_d = 1'b1;
          rb_data_d  = capture << (3'd7 - bcnt_q);
        end else if (bcnt_q == 3'd7) begin
          state_d    = ST_WAIT_BYTE;
          rb_valid_d = 1'b1;
          rb_data_d  = capture;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      bcnt_q     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bcnt_q     <= bcnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign in_ready = (state_q == ST_WAIT_BYTE);
  assign setup    = (state_q == ST_SHIFT);
  assign param_in = setup & ser_out;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
module tb_bnn_param_loader;

  localparam int NA = 2;
  localparam int TA = NA * 11;
  localparam int NB = 8;
  localparam int TB = NB * 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel chooses which loader the shared stimulus drives (0: NEURONS=2, 1: NEURONS=8)
  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic a_in_ready, a_setup, a_param_in, a_param_out, a_busy, a_done, a_rb_valid;
  logic [7:0] a_rb_data;
  logic b_in_ready, b_setup, b_param_in, b_param_out, b_busy, b_done, b_rb_valid;
  logic [7:0] b_rb_data;

  // Behavioural neuron chains: one bit per position, shifted on setup
  logic [TA-1:0] chain_a = '0;
  logic [TB-1:0] chain_b = '0;
  always @(posedge clk) if (a_setup) chain_a <= {chain_a[TA-2:0], a_param_in};
  always @(posedge clk) if (b_setup) chain_b <= {chain_b[TB-2:0], b_param_in};
  assign a_param_out = chain_a[TA-1];
  assign b_param_out = chain_b[TB-1];

  bnn_param_loader #(.NEURONS(NA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .in_data(in_data),
    .in_valid(in_valid && !sel), .in_ready(a_in_ready), .setup(a_setup),
    .param_in(a_param_in), .param_out(a_param_out), .busy(a_busy), .done(a_done),
    .rb_data(a_rb_data), .rb_valid(a_rb_valid)
  );

  bnn_param_loader #(.NEURONS(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .in_data(in_data),
    .in_valid(in_valid && sel), .in_ready(b_in_ready), .setup(b_setup),
    .param_in(b_param_in), .param_out(b_param_out), .busy(b_busy), .done(b_done),
    .rb_data(b_rb_data), .rb_valid(b_rb_valid)
  );

  logic m_ready, m_setup, m_param_in, m_busy, m_done, m_rbv;
  logic [7:0] m_rbd;
  assign m_ready    = sel ? b_in_ready : a_in_ready;
  assign m_setup    = sel ? b_setup    : a_setup;
  assign m_param_in = sel ? b_param_in : a_param_in;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;
  assign m_rbv      = sel ? b_rb_valid : a_rb_valid;
  assign m_rbd      = sel ? b_rb_data  : a_rb_data;

  // Monitor, sampled on the inactive edge
  int mon_setup = 0, mon_overlap = 0, mon_ready = 0, mon_done = 0;
  int mon_rb_in_done = 0, mon_rst_setup = 0;
  logic [7:0] rb_log[$];

  always @(negedge clk) begin
    if (m_setup === 1'b1) mon_setup++;
    if (m_setup === 1'b1 && m_ready === 1'b1) mon_overlap++;
    if (m_ready === 1'b1) mon_ready++;
    if (m_done === 1'b1) mon_done++;
    if (m_rbv === 1'b1) begin
      rb_log.push_back(m_rbd);
      if (m_done === 1'b1) mon_rb_in_done++;
    end
    if (!rst_n && (a_setup !== 1'b0 || b_setup !== 1'b0)) mon_rst_setup++;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: chain contents kept as a bit list in tail-first order.
  // A load pushes out the old list (that is the readback) and leaves the
  // new stream in its place.
  bit ref_a[$];
  bit ref_b[$];
  bit strm[$];
  logic [7:0] pay[0:15];
  int npay;

  task automatic build_stream(input int T);
    strm = {};
    for (int j = 0; j < npay; j++)
      for (int k = 0; k < 8; k++)
        strm.push_back(pay[j][7-k]);
    while (strm.size() > T) void'(strm.pop_back());
  endtask

  int d_setup, d_done, d_overlap, d_rb_in_done, d_timeout, rb_base;

  task automatic do_load(input int gap_max, input bit poke_start, input int abort_at);
    int s_setup, s_done, s_ovl, s_rbd, guard, g;
    s_setup = mon_setup; s_done = mon_done; s_ovl = mon_overlap; s_rbd = mon_rb_in_done;
    rb_base = rb_log.size();
    d_timeout = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < npay; j++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      in_data = pay[j];
      in_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (m_ready !== 1'b1 && guard < 50);
      if (m_ready !== 1'b1) d_timeout++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = 8'($urandom);
      if (j == abort_at) begin
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 chk("async reset mid-shift outputs",
               {m_ready, m_setup, m_param_in, m_busy, m_done, m_rbv, m_rbd}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      if (poke_start && j == 0) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    guard = 0;
    while (m_done !== 1'b1 && guard < 80) begin @(negedge clk); guard++; end
    if (m_done !== 1'b1) d_timeout++;
    repeat (3) begin @(posedge clk); #1; end
    d_setup = mon_setup - s_setup;
    d_done = mon_done - s_done;
    d_overlap = mon_overlap - s_ovl;
    d_rb_in_done = mon_rb_in_done - s_rbd;
  endtask

  task automatic verify_load(input string tag);
    bit old[$];
    int T, nb, rbn;
    logic [7:0] eb, ob;
    logic [127:0] ec, oc;
    T = sel ? TB : TA;
    if (sel) old = ref_b; else old = ref_a;
    build_stream(T);
    nb = (T + 7) / 8;
    chk({tag, " timeouts"}, d_timeout, 0);
    chk({tag, " setup cycles"}, d_setup, T);
    chk({tag, " done pulses"}, d_done, 1);
    chk({tag, " setup while in_ready"}, d_overlap, 0);
    chk({tag, " last rb_valid in done"}, d_rb_in_done, 1);
    rbn = rb_log.size() - rb_base;
    chk({tag, " rb_valid pulses"}, rbn, nb);
    for (int b = 0; b < nb; b++) begin
      eb = 8'h00;
      for (int k = 0; k < 8; k++)
        if (b * 8 + k < T) eb[7-k] = old[b*8+k];
      ob = (b < rbn) ? rb_log[rb_base+b] : 8'hxx;
      chk($sformatf("%s rb byte %0d", tag, b), ob, eb);
    end
    ec = '0;
    for (int i = 0; i < T; i++) ec[T-1-i] = strm[i];
    oc = sel ? 128'(chain_b) : 128'(chain_a);
    chk({tag, " chain contents"}, oc, ec);
    if (sel) ref_b = strm; else ref_a = strm;
  endtask

  task automatic check_fields_a(input string tag);
    chk({tag, " neuron1 bias"}, chain_a[21:19], 3'd5);
    chk({tag, " neuron1 weights"}, chain_a[18:11], 8'h29);
    chk({tag, " neuron0 bias"}, chain_a[10:8], 3'd7);
    chk({tag, " neuron0 weights"}, chain_a[7:0], 8'h3C);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, k;
    bit nq[$];
    for (int i = 0; i < TA; i++) ref_a.push_back(1'b0);
    for (int i = 0; i < TB; i++) ref_b.push_back(1'b0);

    // Reset with garbage on the inputs
    start = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    repeat (4) begin @(posedge clk); #1 sel = ~sel; in_data = 8'($urandom); end
    @(negedge clk);
    chk("reset outputs A", {a_in_ready, a_setup, a_param_in, a_busy, a_done, a_rb_valid, a_rb_data}, 0);
    chk("reset outputs B", {b_in_ready, b_setup, b_param_in, b_busy, b_done, b_rb_valid, b_rb_data}, 0);
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b0; sel = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("setup during reset", mon_rst_setup, 0);

    // Directed load into a zeroed two-neuron chain
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hF0; npay = 3;
    do_load(0, 1'b0, -1);
    verify_load("A load1");
    check_fields_a("A load1");

    // Same load again with start poked mid-shift: readback returns first load
    do_load(2, 1'b1, -1);
    verify_load("A load2");
    check_fields_a("A load2");

    // in_valid held in IDLE must not be accepted
    in_data = 8'hFF; in_valid = 1'b1;
    r0 = mon_ready; s0 = mon_setup;
    repeat (12) begin @(posedge clk); #1; end
    chk("idle in_ready cycles", mon_ready - r0, 0);
    chk("idle setup cycles", mon_setup - s0, 0);
    @(negedge clk);
    chk("idle busy", m_busy, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;

    // Eight-neuron chain, random bytes with random valid gaps
    sel = 1'b1;
    for (int j = 0; j < 11; j++) pay[j] = 8'($urandom);
    npay = 11;
    do_load(4, 1'b0, -1);
    verify_load("B load1");
    for (int j = 0; j < 11; j++) pay[j] = 8'($urandom);
    do_load(4, 1'b0, -1);
    verify_load("B load2");

    // Reset in the middle of the second byte, then a complete reload
    sel = 1'b0;
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h0F; npay = 3;
    s0 = mon_setup;
    do_load(0, 1'b0, 1);
    k = mon_setup - s0;
    build_stream(TA);
    nq = {};
    for (int i = k; i < TA; i++) nq.push_back(ref_a[i]);
    for (int i = 0; i < k && i < TA; i++) nq.push_back(strm[i]);
    ref_a = nq;
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hF0; npay = 3;
    do_load(1, 1'b0, -1);
    verify_load("A reload");
    check_fields_a("A reload");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Serial parameter loader that sits directly upstream of the BNN neuron chain. It accepts parameter bytes over a valid/ready byte port and serializes them MSB-first onto the chain's `setup`/`param_in` shift interface, one bit per `setup` cycle, until exactly `NEURONS*11` bits have been shifted. It simultaneously captures the bits falling out of the chain tail (`param_out`) and returns them as readback bytes, so previously loaded parameters can be verified.

## Interface
- `NEURONS`, default 8: number of neurons daisy-chained on the parameter shift path.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_data`  in  8  parameter byte, stream order MSB first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte.
- `setup`  out  1  chain shift enable, to first neuron `setup`, fanned out to all.
- `param_in`  out  1  serial bit to first neuron `param_in`.
- `param_out`  in  1  serial bit from last neuron `param_out`.
- `busy`  out  1  load in progress (state != IDLE).
- `done`  out  1  one-cycle pulse, load complete.
- `rb_data`  out  8  readback byte, first-captured bit at MSB.
- `rb_valid`  out  1  one-cycle pulse, `rb_data` valid; no backpressure.

## Operation
- TOTAL = `NEURONS*11` bits; BYTES = ceil(TOTAL/8). Bit counter width clog2(TOTAL+1).
- Stream order: last neuron first; within a neuron bias[2:0] MSB first, then weights[7:0] MSB first. Stream bit k of byte j is `in_data[7-k]` of the j-th accepted byte.
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- IDLE: `in_ready`=0, `setup`=0. `start`=1 -> WAIT_BYTE, clear bit counter and readback register.
- WAIT_BYTE: `in_ready`=1. On `in_valid & in_ready`, latch byte into 8-bit PISO, clear per-byte counter -> SHIFT.
- SHIFT: `setup`=1, `param_in`=PISO[7]. Each cycle: PISO shifts left, bit counter +1, `param_out` shifted into readback SIPO LSB. After 8 bits -> WAIT_BYTE; when bit counter reaches TOTAL -> DONE (takes priority, may occur mid-byte).
- DONE: `done`=1 for one cycle -> IDLE.
- Final partial byte: only the top (TOTAL mod 8) bits are shifted; remaining low bits discarded.
- `start` outside IDLE ignored. `in_valid` outside WAIT_BYTE ignored (not consumed).
- Readback: `rb_valid` pulses in the cycle after every 8th captured bit; on a partial final byte it pulses in DONE with captured bits left-justified, low bits 0.
- Reset mid-load: all state to IDLE immediately; chain left partially shifted (no rollback); next load must be a complete one.

## Timing
- Reset values: `in_ready`=0, `setup`=0, `param_in`=0, `busy`=0, `done`=0, `rb_data`=0x00, `rb_valid`=0; state IDLE.
- All outputs derive from registers only; no combinational path from any input to any output.
- `start` at edge t -> `in_ready`=1 from t+1.
- Byte accepted at edge t -> `setup`=1 on cycles t+1..t+8 (neuron samples on edges t+2..t+9); `in_ready` back at t+9. Full-byte throughput: 9 cycles/byte.
- `param_out` sampled on the same edge the chain shifts (pre-shift tail value).
- `done` asserted the cycle after the last `setup` cycle; `busy` falls with the return to IDLE.

## Structure
- Shared package `bnn_pkg`: `WEIGHT_BITS`=8, `BIAS_BITS`=3, `BITS_PER_NEURON`=11, loader state enum.
- One sub-module: `param_serializer` (8-bit PISO plus readback SIPO with shift/load/clear controls); FSM and counters stay in `bnn_param_loader`.

## Test plan
- Reset: `rst_n`=0 with garbage on inputs -> all outputs at reset values, `setup` never asserted.
- NEURONS=2, zeroed chain, load 0xA5,0x3C,0xF0 -> exactly 22 `setup` cycles; neuron1 bias=5 weights=0x29, neuron0 bias=7 weights=0x3C; `done` one pulse; `rb_data` 0x00,0x00,0x00.
- Repeat same load -> readback 0xA5,0x3C,0xF0 (last pulse in DONE); chain contents unchanged.
- NEURONS=8, 11 bytes with random `in_valid` gaps -> 88 `setup` cycles, `setup` never high while WAIT_BYTE, 11 `rb_valid` pulses.
- `start` pulsed during SHIFT and `in_valid` held high in IDLE -> no restart, no byte consumed, `in_ready`=0.
- `rst_n` low mid-SHIFT of byte 2 -> outputs reset asynchronously; subsequent full load of 0xA5,0x3C,0xF0 gives neuron1 bias=5 weights=0x29, neuron0 bias=7 weights=0x3C.
